sal_cmd_sched: RTL and testbench
================================

// Module: sal_cmd_sched
// PURPOSE
//  Grant side of the per-bank scheduling handshake; one instance per channel.
//  - Collects ACT/RD/WR/PRE/REF requests from NUM_BANKS bank controllers.
//  - Grants at most one request per cycle, in the same cycle it is requested.
//  - Enforces inter-bank timing (tRRD, tCCD, tWTR, tRTW).
//  - Drives the granted command, registered, toward the DRAM command bus.
// PARAMETERS
//  NUM_BANKS   4   bank controllers served (power of 2, >=2)
//  RA_WIDTH    16  row address width
//  CA_WIDTH    10  column address width
//  ID_WIDTH    8   request id width
//  LEN_WIDTH   4   burst length field width
//  T_RRD       4   min cycles ACT->ACT (any banks), >=1
//  T_CCD       4   min cycles RD/WR->RD/WR, >=1
//  T_WTR       8   min cycles WR->RD, >=1
//  T_RTW       6   min cycles RD->WR, >=1
// PORTS
//  clk        in   1                 clock
//  rst        in   1                 asynchronous active-high reset
//  act_req_i  in   NUM_BANKS         per-bank ACTIVATE request
//  rd_req_i   in   NUM_BANKS         per-bank READ request
//  wr_req_i   in   NUM_BANKS         per-bank WRITE request
//  pre_req_i  in   NUM_BANKS         per-bank PRECHARGE request
//  ref_req_i  in   NUM_BANKS         per-bank REFRESH request
//  ra_i       in   NUM_BANKS*RA_W    per-bank row address, bank b at [b*RA_W +: RA_W]
//  ca_i       in   NUM_BANKS*CA_W    per-bank column address, same packing
//  id_i       in   NUM_BANKS*ID_W    per-bank id, same packing
//  len_i      in   NUM_BANKS*LEN_W   per-bank length, same packing
//  act_gnt_o  out  NUM_BANKS         grant vectors, combinational; all five together one-hot or zero
//  rd_gnt_o   out  NUM_BANKS
//  wr_gnt_o   out  NUM_BANKS
//  pre_gnt_o  out  NUM_BANKS
//  ref_gnt_o  out  NUM_BANKS
//  cmd_valid_o out 1                 registered command strobe
//  cmd_o      out  3                 0=NOP 1=ACT 2=RD 3=WR 4=PRE 5=REF
//  cmd_ba_o   out  log2(NUM_BANKS)   bank of issued command
//  cmd_ra_o / cmd_ca_o / cmd_id_o / cmd_len_o  out  widths as above
// BEHAVIOUR
//  - Reset (rst=1, async): all counters 0, rr pointers 0, cmd_valid_o 0, cmd_o NOP.
//    All *_gnt_o are forced 0 while rst=1.
//  - Grant is same-cycle, combinational from req + counter state; no grant without a matching req.
//  - Class priority: REF > RD/WR (column) > ACT > PRE.
//    Grant goes to the highest class with an eligible request.
//  - Within a class: round-robin over banks from ptr_<class>.
//    After a grant, ptr = granted bank + 1 (mod NUM_BANKS).
//  - RD and WR share the column pointer and class.
//    A bank raises at most one of rd/wr/act/pre/ref per cycle.
//    If it raises several, priority order applies within that bank.
//  - Eligibility:
//    ACT needs rrd_cnt==0.
//    RD needs ccd_cnt==0 && wtr_cnt==0.
//    WR needs ccd_cnt==0 && rtw_cnt==0.
//    PRE and REF are always eligible (per-bank timing is the bank controller's job).
//  - Counters: on a grant, load T_x-1; otherwise decrement while >0, saturating at 0.
//    Result: same-constraint commands are exactly T_x cycles apart at minimum.
//    ACT loads rrd. RD loads ccd and rtw. WR loads ccd and wtr.
//  - Counter width = $clog2(max T)+1; T_x=1 means back-to-back allowed.
//  - Command register: cycle after a grant, cmd_valid_o=1 with type, bank and fields of the granted bank.
//    Otherwise cmd_valid_o=0 and cmd_o=NOP; other fields hold their last value.
//  - Latency: req->gnt 0 cycles; gnt->cmd_valid_o 1 cycle.
//  - Blocked request stays pending; no starvation within a class thanks to RR.
//    Lower classes may starve under continuous higher-class traffic (by design).
//  - Reset mid-operation: pending counters are cleared immediately.
//    A command registered in that cycle is dropped.
// TESTING
//  1. Single bank 2 ACT at cycle 5: act_gnt_o=4'b0100 at cycle 5;
//     cycle 6 cmd_valid_o=1, cmd_o=1, cmd_ba_o=2, cmd_ra_o=ra_i[2].
//  2. Banks 0,1 hold act_req from cycle 0, T_RRD=4: grants at cycle 0 (bank0), then cycle 4 (bank1), no ACT at 1-3.
//  3. Bank 0 WR granted at cycle 10, bank 1 holds RD, T_WTR=8: rd_gnt_o[1] first asserted at cycle 18.
//  4. All 4 banks hold rd_req, T_CCD=4, ptr=0: grants to banks 0,1,2,3 at cycles 0,4,8,12, then bank 0 at 16.
//  5. Same cycle: ref_req_i[3], rd_req_i[0], act_req_i[1]: ref_gnt_o[3]=1 only;
//     next cycle (rd still eligible) rd_gnt_o[0]=1.
//  6. Assert rst at cycle 2 after RD granted at cycle 1 with T_CCD=4:
//     grants 0, cmd_valid_o=0 during reset; after release a RD is grantable immediately.

Source files
------------

// File: rtl/sal_cmd_sched.sv
// Per-channel DRAM command scheduler. Grants one bank request per cycle, in priority
// order REF > RD/WR > ACT > PRE, enforces inter-bank timing and registers the granted command.
module sal_cmd_sched #(
  parameter int NUM_BANKS = 4,
  parameter int RA_WIDTH  = 16,
  parameter int CA_WIDTH  = 10,
  parameter int ID_WIDTH  = 8,
  parameter int LEN_WIDTH = 4,
  parameter int T_RRD     = 4,
  parameter int T_CCD     = 4,
  parameter int T_WTR     = 8,
  parameter int T_RTW     = 6
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_BANKS-1:0]              act_req_i,
  input  logic [NUM_BANKS-1:0]              rd_req_i,
  input  logic [NUM_BANKS-1:0]              wr_req_i,
  input  logic [NUM_BANKS-1:0]              pre_req_i,
  input  logic [NUM_BANKS-1:0]              ref_req_i,
  input  logic [NUM_BANKS*RA_WIDTH-1:0]     ra_i,
  input  logic [NUM_BANKS*CA_WIDTH-1:0]     ca_i,
  input  logic [NUM_BANKS*ID_WIDTH-1:0]     id_i,
  input  logic [NUM_BANKS*LEN_WIDTH-1:0]    len_i,
  output logic [NUM_BANKS-1:0]              act_gnt_o,
  output logic [NUM_BANKS-1:0]              rd_gnt_o,
  output logic [NUM_BANKS-1:0]              wr_gnt_o,
  output logic [NUM_BANKS-1:0]              pre_gnt_o,
  output logic [NUM_BANKS-1:0]              ref_gnt_o,
  output logic                              cmd_valid_o,
  output logic [2:0]                        cmd_o,
  output logic [$clog2(NUM_BANKS)-1:0]      cmd_ba_o,
  output logic [RA_WIDTH-1:0]               cmd_ra_o,
  output logic [CA_WIDTH-1:0]               cmd_ca_o,
  output logic [ID_WIDTH-1:0]               cmd_id_o,
  output logic [LEN_WIDTH-1:0]              cmd_len_o
);
  localparam int BW    = $clog2(NUM_BANKS);
  localparam int T_M1  = (T_RRD > T_CCD) ? T_RRD : T_CCD;
  localparam int T_M2  = (T_WTR > T_RTW) ? T_WTR : T_RTW;
  localparam int T_MAX = (T_M1 > T_M2) ? T_M1 : T_M2;
  localparam int CW    = $clog2(T_MAX) + 1;

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_PRE = 3'd4;
  localparam logic [2:0] CMD_REF = 3'd5;

  logic [CW-1:0]        r_rrd_cnt, r_ccd_cnt, r_wtr_cnt, r_rtw_cnt;
  logic [BW-1:0]        r_ptr_ref, r_ptr_col, r_ptr_act, r_ptr_pre;
  logic [NUM_BANKS-1:0] w_ref_m, w_rd_m, w_wr_m, w_act_m, w_pre_m;
  logic [NUM_BANKS-1:0] w_rd_e, w_wr_e, w_col_e, w_act_e;
  logic [NUM_BANKS-1:0] w_ref_pick, w_col_pick, w_act_pick, w_pre_pick;
  logic [NUM_BANKS-1:0] w_gnt_vec;
  logic                 w_gnt_any, w_rd_ok, w_wr_ok, w_act_ok;
  logic [2:0]           w_gnt_cmd;
  logic [BW-1:0]        w_gnt_ba;

  // First requesting bank at or after ptr, wrapping modulo NUM_BANKS.
  function automatic logic [NUM_BANKS-1:0] rr_pick(input logic [NUM_BANKS-1:0] req,
                                                    input logic [BW-1:0] ptr);
    logic [NUM_BANKS-1:0] gnt;
    logic                 found;
    logic [BW-1:0]        idx;
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      idx = ptr + BW'(i);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return gnt;
  endfunction

  function automatic logic [BW-1:0] onehot_idx(input logic [NUM_BANKS-1:0] vec);
    logic [BW-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_BANKS; i++)
      if (vec[i]) idx = idx | BW'(i);
    return idx;
  endfunction

  function automatic logic [CW-1:0] dec_sat(input logic [CW-1:0] cnt);
    return (cnt == '0) ? '0 : cnt - CW'(1);
  endfunction

  // A bank raising several requests keeps only its highest-priority one.
  assign w_ref_m = ref_req_i;
  assign w_rd_m  = rd_req_i  & ~ref_req_i;
  assign w_wr_m  = wr_req_i  & ~ref_req_i & ~rd_req_i;
  assign w_act_m = act_req_i & ~ref_req_i & ~rd_req_i & ~wr_req_i;
  assign w_pre_m = pre_req_i & ~ref_req_i & ~rd_req_i & ~wr_req_i & ~act_req_i;

  assign w_rd_ok  = (r_ccd_cnt == '0) && (r_wtr_cnt == '0);
  assign w_wr_ok  = (r_ccd_cnt == '0) && (r_rtw_cnt == '0);
  assign w_act_ok = (r_rrd_cnt == '0);

  assign w_rd_e  = w_rd_m  & {NUM_BANKS{w_rd_ok}};
  assign w_wr_e  = w_wr_m  & {NUM_BANKS{w_wr_ok}};
  assign w_col_e = w_rd_e | w_wr_e;
  assign w_act_e = w_act_m & {NUM_BANKS{w_act_ok}};

  assign w_ref_pick = rr_pick(w_ref_m, r_ptr_ref);
  assign w_col_pick = rr_pick(w_col_e, r_ptr_col);
  assign w_act_pick = rr_pick(w_act_e, r_ptr_act);
  assign w_pre_pick = rr_pick(w_pre_m, r_ptr_pre);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    act_gnt_o = '0;
    rd_gnt_o  = '0;
    wr_gnt_o  = '0;
    pre_gnt_o = '0;
    ref_gnt_o = '0;
    w_gnt_cmd = CMD_NOP;
    if (!rst) begin
      if (|w_ref_m) begin
        ref_gnt_o = w_ref_pick;
        w_gnt_cmd = CMD_REF;
      end else if (|w_col_e) begin
        rd_gnt_o  = w_col_pick & w_rd_e;
        wr_gnt_o  = w_col_pick & w_wr_e;
        w_gnt_cmd = (|(w_col_pick & w_rd_e)) ? CMD_RD : CMD_WR;
      end else if (|w_act_e) begin
        act_gnt_o = w_act_pick;
        w_gnt_cmd = CMD_ACT;
      end else if (|w_pre_m) begin
        pre_gnt_o = w_pre_pick;
        w_gnt_cmd = CMD_PRE;
      end
    end
  end

  assign w_gnt_vec = act_gnt_o | rd_gnt_o | wr_gnt_o | pre_gnt_o | ref_gnt_o;
  assign w_gnt_any = |w_gnt_vec;
  assign w_gnt_ba  = onehot_idx(w_gnt_vec);

  // Counters load T-1 on the constraining grant, so the next one lands exactly T cycles later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rrd_cnt <= '0;
      r_ccd_cnt <= '0;
      r_wtr_cnt <= '0;
      r_rtw_cnt <= '0;
      r_ptr_ref <= '0;
      r_ptr_col <= '0;
      r_ptr_act <= '0;
      r_ptr_pre <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_rrd_cnt <= (|act_gnt_o) ? CW'(T_RRD - 1) : dec_sat(r_rrd_cnt);
      r_ccd_cnt <= (|(rd_gnt_o | wr_gnt_o)) ? CW'(T_CCD - 1) : dec_sat(r_ccd_cnt);
      r_wtr_cnt <= (|wr_gnt_o) ? CW'(T_WTR - 1) : dec_sat(r_wtr_cnt);
      r_rtw_cnt <= (|rd_gnt_o) ? CW'(T_RTW - 1) : dec_sat(r_rtw_cnt);
      if (|ref_gnt_o)              r_ptr_ref <= w_gnt_ba + BW'(1);
      if (|(rd_gnt_o | wr_gnt_o))  r_ptr_col <= w_gnt_ba + BW'(1);
      if (|act_gnt_o)              r_ptr_act <= w_gnt_ba + BW'(1);
      if (|pre_gnt_o)              r_ptr_pre <= w_gnt_ba + BW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_valid_o <= 1'b0;
      cmd_o       <= CMD_NOP;
      cmd_ba_o    <= '0;
      cmd_ra_o    <= '0;
      cmd_ca_o    <= '0;
      cmd_id_o    <= '0;
      cmd_len_o   <= '0;
    end else if (w_gnt_any) begin
      cmd_valid_o <= 1'b1;
      cmd_o       <= w_gnt_cmd;
      cmd_ba_o    <= w_gnt_ba;
      cmd_ra_o    <= ra_i[w_gnt_ba*RA_WIDTH +: RA_WIDTH];
      cmd_ca_o    <= ca_i[w_gnt_ba*CA_WIDTH +: CA_WIDTH];
      cmd_id_o    <= id_i[w_gnt_ba*ID_WIDTH +: ID_WIDTH];
      cmd_len_o   <= len_i[w_gnt_ba*LEN_WIDTH +: LEN_WIDTH];
    end else begin
      cmd_valid_o <= 1'b0;
      cmd_o       <= CMD_NOP;
    end
  end

endmodule

// File: tb/tb_sal_cmd_sched.sv
// Randomised scoreboard bench for sal_cmd_sched: a timestamp-based model predicts each
// cycle's grant and queues the command expected on the registered bus one cycle later.
module tb_sal_cmd_sched;
  localparam int N = 4, RA_W = 16, CA_W = 10, ID_W = 8, LEN_W = 4;
  localparam int T_RRD = 4, T_CCD = 4, T_WTR = 8, T_RTW = 6;

  typedef enum int {K_NONE = 0, K_ACT = 1, K_RD = 2, K_WR = 3, K_PRE = 4, K_REF = 5} kind_t;
  typedef struct packed {
    logic [2:0]       cmd;
    logic [1:0]       ba;
    logic [RA_W-1:0]  ra;
    logic [CA_W-1:0]  ca;
    logic [ID_W-1:0]  id;
    logic [LEN_W-1:0] len;
  } cmd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] act_req, rd_req, wr_req, pre_req, ref_req;
  logic [N*RA_W-1:0] ra;
  logic [N*CA_W-1:0] ca;
  logic [N*ID_W-1:0] id;
  logic [N*LEN_W-1:0] len;
  logic [N-1:0] act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
  logic cmd_valid;
  logic [2:0] cmd;
  logic [1:0] cmd_ba;
  logic [RA_W-1:0] cmd_ra;
  logic [CA_W-1:0] cmd_ca;
  logic [ID_W-1:0] cmd_id;
  logic [LEN_W-1:0] cmd_len;

  sal_cmd_sched #(
    .NUM_BANKS(N), .RA_WIDTH(RA_W), .CA_WIDTH(CA_W), .ID_WIDTH(ID_W), .LEN_WIDTH(LEN_W),
    .T_RRD(T_RRD), .T_CCD(T_CCD), .T_WTR(T_WTR), .T_RTW(T_RTW)
  ) dut (
    .clk(clk), .rst(rst),
    .act_req_i(act_req), .rd_req_i(rd_req), .wr_req_i(wr_req), .pre_req_i(pre_req), .ref_req_i(ref_req),
    .ra_i(ra), .ca_i(ca), .id_i(id), .len_i(len),
    .act_gnt_o(act_gnt), .rd_gnt_o(rd_gnt), .wr_gnt_o(wr_gnt), .pre_gnt_o(pre_gnt), .ref_gnt_o(ref_gnt),
    .cmd_valid_o(cmd_valid), .cmd_o(cmd), .cmd_ba_o(cmd_ba), .cmd_ra_o(cmd_ra),
    .cmd_ca_o(cmd_ca), .cmd_id_o(cmd_id), .cmd_len_o(cmd_len)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  cmd_t exp_q[$];

  // Model state: per-bank pending request and the cycle of the last command of each kind.
  kind_t            pend [N];
  logic [RA_W-1:0]  b_ra [N];
  logic [CA_W-1:0]  b_ca [N];
  logic [ID_W-1:0]  b_id [N];
  logic [LEN_W-1:0] b_len[N];
  int cyc, last_act, last_col, last_rd, last_wr;
  int ptr_ref, ptr_col, ptr_act, ptr_pre;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
    end
  endtask

  function automatic int rr(input int p, input logic [N-1:0] m);
    for (int k = 0; k < N; k++)
      if (m[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    cyc = 0;
    last_act = -1000; last_col = -1000; last_rd = -1000; last_wr = -1000;
    ptr_ref = 0; ptr_col = 0; ptr_act = 0; ptr_pre = 0;
  endtask

  task automatic drive();
    for (int b = 0; b < N; b++) begin
      act_req[b] = (pend[b] == K_ACT);
      rd_req[b]  = (pend[b] == K_RD);
      wr_req[b]  = (pend[b] == K_WR);
      pre_req[b] = (pend[b] == K_PRE);
      ref_req[b] = (pend[b] == K_REF);
      ra[b*RA_W +: RA_W]    = b_ra[b];
      ca[b*CA_W +: CA_W]    = b_ca[b];
      id[b*ID_W +: ID_W]    = b_id[b];
      len[b*LEN_W +: LEN_W] = b_len[b];
    end
  endtask

  task automatic set_req(input int b, input kind_t k);
    pend[b]  = k;
    b_ra[b]  = RA_W'($urandom);
    b_ca[b]  = CA_W'($urandom);
    b_id[b]  = ID_W'($urandom);
    b_len[b] = LEN_W'($urandom);
  endtask

  task automatic clear_all();
    for (int b = 0; b < N; b++) pend[b] = K_NONE;
  endtask

  // One clock cycle: drive pending requests, predict and check the grant, queue the command.
  task automatic step();
    logic [N-1:0] m_ref, m_col, m_act, m_pre;
    logic [N-1:0] e_ref, e_rd, e_wr, e_act, e_pre;
    bit rd_ok, wr_ok, act_ok;
    int b;
    cmd_t c;
    @(negedge clk);
    drive();
    #1;
    rd_ok  = (cyc - last_col >= T_CCD) && (cyc - last_wr >= T_WTR);
    wr_ok  = (cyc - last_col >= T_CCD) && (cyc - last_rd >= T_RTW);
    act_ok = (cyc - last_act >= T_RRD);
    for (int i = 0; i < N; i++) begin
      m_ref[i] = (pend[i] == K_REF);
      m_col[i] = (pend[i] == K_RD && rd_ok) || (pend[i] == K_WR && wr_ok);
      m_act[i] = (pend[i] == K_ACT) && act_ok;
      m_pre[i] = (pend[i] == K_PRE);
    end
    {e_ref, e_rd, e_wr, e_act, e_pre} = '0;
    b = -1;
    if (m_ref != 0) begin
      b = rr(ptr_ref, m_ref); ptr_ref = (b + 1) % N; e_ref[b] = 1'b1;
    end else if (m_col != 0) begin
      b = rr(ptr_col, m_col); ptr_col = (b + 1) % N; last_col = cyc;
      if (pend[b] == K_RD) begin e_rd[b] = 1'b1; last_rd = cyc; end
      else begin e_wr[b] = 1'b1; last_wr = cyc; end
    end else if (m_act != 0) begin
      b = rr(ptr_act, m_act); ptr_act = (b + 1) % N; e_act[b] = 1'b1; last_act = cyc;
    end else if (m_pre != 0) begin
      b = rr(ptr_pre, m_pre); ptr_pre = (b + 1) % N; e_pre[b] = 1'b1;
    end
    check("grant", 64'({ref_gnt, rd_gnt, wr_gnt, act_gnt, pre_gnt}),
          64'({e_ref, e_rd, e_wr, e_act, e_pre}));
    if (b >= 0) begin
      c.cmd = 3'(int'(pend[b]));
      c.ba  = 2'(b);
      c.ra  = b_ra[b];
      c.ca  = b_ca[b];
      c.id  = b_id[b];
      c.len = b_len[b];
      exp_q.push_back(c);
      pend[b] = K_NONE;
    end
    cyc++;
  endtask

  // Assert reset with every bank requesting REF: grants and the command strobe must stay low.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int b = 0; b < N; b++) set_req(b, K_REF);
    drive();
    #1;
    check("rst_grants", 64'({ref_gnt, rd_gnt, wr_gnt, act_gnt, pre_gnt}), 64'(0));
    check("rst_cmd", 64'({cmd_valid, cmd}), 64'(0));
    @(posedge clk);
    #1;
    check("rst_cmd_held", 64'({cmd_valid, cmd}), 64'(0));
    @(negedge clk);
    clear_all();
    drive();
    rst = 1'b0;
    model_reset();
  endtask

  // Monitor: every registered command must match the oldest queued expectation.
  initial begin
    cmd_t got;
    cmd_t exp;
    forever begin
      @(posedge clk);
      #1;
      got = {cmd, cmd_ba, cmd_ra, cmd_ca, cmd_id, cmd_len};
      if (cmd_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cmd_unexpected at %0t: got %h, expected no command", $time, got);
        end else begin
          exp = exp_q.pop_front();
          check("cmd", 64'(got), 64'(exp));
        end
      end else begin
        check("idle_nop", 64'(cmd), 64'(0));
      end
    end
  end

  initial begin
    int r;
    clear_all();
    for (int b = 0; b < N; b++) set_req(b, K_NONE);
    drive();
    model_reset();
    do_reset();

    // Single ACT on bank 2 after a few idle cycles.
    repeat (5) step();
    set_req(2, K_ACT);
    step();
    repeat (2) step();

    // Two banks holding ACT: tRRD spacing.
    do_reset();
    set_req(0, K_ACT); set_req(1, K_ACT);
    repeat (6) step();

    // WR on bank 0 then RD on bank 1 blocked by tWTR.
    do_reset();
    set_req(0, K_WR); set_req(1, K_RD);
    repeat (10) step();

    // All banks reading: round-robin at tCCD spacing, bank 0 re-requests.
    do_reset();
    for (int b = 0; b < N; b++) set_req(b, K_RD);
    repeat (13) step();
    set_req(0, K_RD);
    repeat (5) step();

    // Class priority: REF beats RD beats ACT.
    do_reset();
    set_req(3, K_REF); set_req(0, K_RD); set_req(1, K_ACT);
    step();
    check("prio_ref", 64'(ref_gnt), 64'(4'b1000));
    step();
    check("prio_rd_next", 64'(rd_gnt), 64'(4'b0001));
    repeat (2) step();

    // Reset right after a RD grant: counters cleared, RD grantable immediately after release.
    do_reset();
    step();
    set_req(0, K_RD);
    step();
    do_reset();
    set_req(0, K_RD);
    step();
    check("rd_after_reset", 64'(rd_gnt), 64'(4'b0001));
    step();

    // Randomised traffic: banks hold requests until granted.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      for (int b = 0; b < N; b++) begin
        if (pend[b] == K_NONE && $urandom_range(0, 1) == 1) begin
          r = $urandom_range(1, 12);
          if (r <= 3)       set_req(b, K_ACT);
          else if (r <= 6)  set_req(b, K_RD);
          else if (r <= 9)  set_req(b, K_WR);
          else if (r <= 11) set_req(b, K_PRE);
          else              set_req(b, K_REF);
        end
      end
      step();
    end

    clear_all();
    step();
    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
